bfxp_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle bit-field extract/place datapath.
- Generalised to XLEN of 32 or 64, with four operation modes: place-OR, zero-extract, sign-extract and insert.
- Valid/ready handshake on both sides; two-stage pipeline with full backpressure.
- Sits between the instruction-issue stage and the writeback arbiter of the bitmanip unit.

---
 rtl/bfxp_pkg.sv | 22 ++
 rtl/bfxp_ror.sv | 13 +
 rtl/bfxp_pipe.sv | 87 ++++++++
 tb/tb_bfxp_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bfxp_pkg.sv
// bfxp_pkg: op encoding, legal XLEN values and field-mask helper shared by bfxp_pipe
package bfxp_pkg;
  typedef enum logic [1:0] {
    BFXP_PLACE  = 2'd0,
    BFXP_EXTZ   = 2'd1,
    BFXP_EXTS   = 2'd2,
    BFXP_INSERT = 2'd3
  } bfxp_op_e;
  localparam int XLEN_32  = 32;
  localparam int XLEN_64  = 64;
  localparam int XLEN_MAX = XLEN_64;
  // Bits [d, min(d+len, xlen)-1] set; the top saturates at xlen so the field never wraps.
  function automatic logic [XLEN_MAX-1:0] bfxp_mask(input int xlen, input int d, input int len);
    int top;
    logic [XLEN_MAX:0] hi, lo, m;
    top = (d + len > xlen) ? xlen : d + len;
    hi = {{XLEN_MAX{1'b0}}, 1'b1} << top;
    lo = {{XLEN_MAX{1'b0}}, 1'b1} << d;
    m = (hi - 1'b1) & ~(lo - 1'b1);
    return m[XLEN_MAX-1:0];
  endfunction
endpackage

// File: rtl/bfxp_ror.sv
// bfxp_ror: combinational XLEN-bit rotate-right
module bfxp_ror #(
  parameter int XLEN = 32,
  parameter int LOGX = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a,
  input  logic [LOGX-1:0] sh,
  output logic [XLEN-1:0] y
);
  logic [2*XLEN-1:0] dbl;
  assign dbl = {a, a} >> sh;
  assign y = dbl[XLEN-1:0];
endmodule

// File: rtl/bfxp_pipe.sv
// bfxp_pipe: two-stage valid/ready bit-field place/extract/insert; BFXP_SEXT_EN enables sign-extract
module bfxp_pipe
  import bfxp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LOGX = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [LOGX-1:0] start,
  input  logic [LOGX-1:0] len,
  input  logic [LOGX-1:0] dest,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd
);
  if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_xlen_bad
    $error("bfxp_pipe: XLEN must be 32 or 64");
  end
  bfxp_op_e          op, s1_op;
  logic              is_ext, adv1, adv2, s1_valid;
  logic [LOGX-1:0]   d, sh;
  logic [XLEN_MAX-1:0] mask_full;
  logic [XLEN-1:0]   rot_n, mask_n, s1_rot, s1_mask, s1_rs2, base, sext, res;
  assign op = bfxp_op_e'(in_op);
  assign is_ext = op == BFXP_EXTZ || op == BFXP_EXTS;
  assign d = is_ext ? '0 : dest;
  assign sh = start - d;
  assign mask_full = bfxp_mask(XLEN, int'(d), int'(len));
  assign mask_n = mask_full[XLEN-1:0];
  assign adv2 = !out_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  assign in_ready = adv1;
  bfxp_ror #(.XLEN(XLEN), .LOGX(LOGX)) u_ror (.a(rs1), .sh(sh), .y(rot_n));
  // Stage 1: capture rotated source, field mask, op and background on accept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op <= BFXP_PLACE;
      s1_rot <= '0;
      s1_mask <= '0;
      s1_rs2 <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_rot <= rot_n;
        s1_mask <= mask_n;
        s1_rs2 <= rs2;
      end
    end
  end
  assign base = s1_rot & s1_mask;
`ifdef BFXP_SEXT_EN
  logic [LOGX-1:0] s1_len;
  logic            sgn;
  // Field length kept alongside stage 1 to locate the sign bit of an extracted field
  always_ff @(posedge clock or posedge reset) begin
    if (reset) s1_len <= '0;
    else if (adv1 && in_valid) s1_len <= len;
  end
  assign sgn = s1_len != '0 && s1_rot[s1_len - 1'b1];
  assign sext = sgn ? base | ~s1_mask : base;
`else
  assign sext = base;
`endif
  // Stage 2 result selection by op
  always_comb
    res = s1_op == BFXP_PLACE  ? base | s1_rs2 :
          s1_op == BFXP_INSERT ? base | (s1_rs2 & ~s1_mask) :
          s1_op == BFXP_EXTS   ? sext : base;
  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      rd <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) rd <= res;
    end
  end
endmodule

// File: tb/tb_bfxp_pipe.sv
// tb_bfxp_pipe: scoreboard bench for bfxp_pipe (XLEN=32); honours BFXP_SEXT_EN
module tb_bfxp_pipe;
  logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [1:0]  in_op = '0;
  logic [31:0] rs1 = '0, rs2 = '0, rd;
  logic [4:0]  start = '0, len = '0, dest = '0;
  int          n_cmp = 0, n_bad = 0, acc;
  logic [31:0] q[$];
`ifdef BFXP_SEXT_EN
  localparam logic [31:0] EXP_SEXT = 32'hFFFF_FFF8;
`else
  localparam logic [31:0] EXP_SEXT = 32'h0000_0008;
`endif

  always #5 clock = ~clock;

  bfxp_pipe #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .rs1(rs1), .rs2(rs2), .start(start), .len(len), .dest(dest),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input int st, input int ln, input int ds);
    logic [31:0] r;
    int          d;
    logic        in_f, src, sb;
    r = '0;
    d = (op == 2'd1 || op == 2'd2) ? 0 : ds;
    sb = (ln > 0) ? a[(st + ln - 1) % 32] : 1'b0;
`ifndef BFXP_SEXT_EN
    sb = 1'b0;
`endif
    for (int i = 0; i < 32; i++) begin
      in_f = i >= d && i < d + ln;
      src = in_f ? a[((st + i - d) % 32 + 32) % 32] : 1'b0;
      case (op)
        2'd0: r[i] = src | b[i];
        2'd1: r[i] = src;
        2'd2: r[i] = in_f ? src : sb;
        default: r[i] = in_f ? src : b[i];
      endcase
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] st, input logic [4:0] ln, input logic [4:0] ds,
                      input logic [31:0] exp, input bit rnd);
    bit done;
    done = 1'b0;
    @(negedge clock);
    in_op = op; rs1 = a; rs2 = b; start = st; len = ln; dest = ds; in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (t > 0) @(negedge clock);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready) begin
        q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clock);
    end
    #1 in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic rand_in();
    in_op = 2'($urandom_range(0, 3));
    rs1 = $urandom;
    rs2 = $urandom;
    start = 5'($urandom_range(0, 31));
    len = 5'($urandom_range(0, 31));
    dest = 5'($urandom_range(0, 31));
  endtask

  task automatic send_rand(input bit rnd);
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  st, ln, ds;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    st = 5'($urandom_range(0, 31));
    ln = 5'($urandom_range(0, 31));
    ds = 5'($urandom_range(0, 31));
    send(op, a, b, st, ln, ds, model(op, a, b, int'(st), int'(ln), int'(ds)), rnd);
  endtask

  task automatic drain();
    @(negedge clock);
    out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clock);
    #2;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Output monitor: pop the oldest expectation on every completed output handshake
  always @(negedge clock) begin
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else check("rd", rd, q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd", rd, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send(2'd0, 32'h0000_00F0, 32'h0000_0001, 5'd4, 5'd4, 5'd8, 32'h0000_0F01, 1'b0);
    @(negedge clock);
    #1 check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clock);
    #1 check("lat_cycle2", 32'(out_valid), 32'd1);
    send(2'd1, 32'hABCD_1234, 32'h0,         5'd8,  5'd8, 5'd20, 32'h0000_0012, 1'b0);
    send(2'd2, 32'h0000_8000, 32'h0,         5'd12, 5'd4, 5'd0,  EXP_SEXT,      1'b0);
    send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  5'd0, 5'd0,  32'h0,         1'b0);
    send(2'd3, 32'h0,         32'hFFFF_FFFF, 5'd0,  5'd8, 5'd16, 32'hFF00_FFFF, 1'b0);
    send(2'd3, 32'hFFFF_FFFF, 32'h0,         5'd0,  5'd8, 5'd28, 32'hF000_0000, 1'b0);
    send(2'd1, 32'hF000_000A, 32'h0,         5'd28, 5'd8, 5'd0,  32'h0000_00AF, 1'b0);
    drain();

    for (int k = 0; k < 150; k++) send_rand(1'b1);
    drain();

    @(negedge clock);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      rand_in();
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        q.push_back(model(in_op, rs1, rs2, int'(start), int'(len), int'(dest)));
        acc++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    #1;
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    if (q.size() != 0) check("bp_hold_rd", rd, q[0]);
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    #1 check("bp_second_valid", 32'(out_valid), 32'd1);
    drain();

    @(negedge clock);
    out_ready = 1'b0;
    send_rand(1'b0);
    send_rand(1'b0);
    @(negedge clock);
    #1 check("mid_full_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rd", rd, 32'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    #1 check("mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(2'd1, 32'hF000_000A, 32'h0, 5'd28, 5'd8, 5'd0, 32'h0000_00AF, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
